// File: rtl/alut_age_checker.sv
// ALUT age-port client: sweeps every entry on request and clears the valid bit of
// entries whose timestamp is older than the latched threshold, backing off on add-port collisions.
module alut_age_checker #(
    parameter int DW = 83,
    parameter int DD = 256,
    parameter int AW = 8
) (
    input  logic          pclk,
    input  logic          p_reset,
    input  logic          check_age,
    input  logic [31:0]   max_age,
    input  logic [31:0]   curr_time,
    input  logic [AW-1:0] mem_addr_add,
    input  logic          mem_write_add,
    input  logic [DW-1:0] mem_read_data_age,
    output logic [AW-1:0] mem_addr_age,
    output logic          mem_write_age,
    output logic [DW-1:0] mem_write_data_age,
    output logic          age_busy,
    output logic          age_done,
    output logic [AW:0]   invalid_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] PTR_LAST = AW'(DD - 1);

    state_t        state_r, state_s;
    logic [AW-1:0] ptr_r, ptr_s;
    logic [31:0]   max_r, now_r;
    logic          coll_r;
    logic [DW-1:0] wdata_r;
    logic [AW:0]   count_r;
    logic          start_s, count_inc_s, latch_s;
    logic          snoop_hit_s, stale_s;
    logic [31:0]   age_s;

    // Age and collision detection against the current pointer
    always_comb begin
        snoop_hit_s = mem_write_add && (mem_addr_add == ptr_r);
        age_s       = now_r - mem_read_data_age[DW-2 -: 32];
        stale_s     = mem_read_data_age[DW-1] && (age_s > max_r);
    end

    // Next-state logic for the sweep
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        start_s     = 1'b0;
        count_inc_s = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (check_age) begin
                    state_s = READ;
                    ptr_s   = {AW{1'b0}};
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                state_s = CHECK;
            end
            CHECK: begin
                // A snooped write during READ or CHECK makes the read data untrustworthy
                if (coll_r || snoop_hit_s) begin
                    state_s = READ;
                end else if (stale_s) begin
                    state_s = WRITE;
                    latch_s = 1'b1;
                end else if (ptr_r == PTR_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = READ;
                    ptr_s   = ptr_r + AW'(1);
                end
            end
            WRITE: begin
                if (snoop_hit_s) begin
                    state_s = READ;
                end else begin
                    count_inc_s = 1'b1;
                    if (ptr_r == PTR_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                        ptr_s   = ptr_r + AW'(1);
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode; the write strobe is gated combinationally so a collision or reset cancels it
    always_comb begin
        mem_addr_age       = ((state_r == READ) || (state_r == CHECK) || (state_r == WRITE)) ? ptr_r : {AW{1'b0}};
        mem_write_age      = (state_r == WRITE) && !snoop_hit_s && !p_reset;
        mem_write_data_age = wdata_r;
        age_busy           = (state_r != IDLE);
        age_done           = (state_r == DONE);
        invalid_count      = count_r;
    end

    // Sweep state, pointer, latched thresholds and invalidation count
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            state_r <= IDLE;
            ptr_r   <= {AW{1'b0}};
            max_r   <= 32'd0;
            now_r   <= 32'd0;
            coll_r  <= 1'b0;
            wdata_r <= {DW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            coll_r  <= (state_r == READ) && snoop_hit_s;
            if (start_s) begin
                max_r   <= max_age;
                now_r   <= curr_time;
                count_r <= {(AW+1){1'b0}};
            end else if (count_inc_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else begin
                count_r <= count_r;
            end
            if (latch_s) begin
                wdata_r <= {1'b0, mem_read_data_age[DW-2:0]};
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

endmodule
